dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (1-cycle read latency) between the core load/store path (requester C) and an auxiliary master (requester A: debug/DMA).
- Grants at most one access per cycle and routes each response back to the requester that issued it.
- C has fixed priority. A bounded-wait counter guarantees that A makes progress.

Parameters:
- MAX_WAIT, 4, cycles A may be refused while requesting before it is force-granted; legal 1..255.
- WAIT_W, 8, width of the wait counter; must satisfy 2**WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- start  in  1  asynchronous active-low reset.
- c_req  in  1  core request valid.
- c_we  in  1  1=write, 0=read.
- c_word_addr  in  30  word address.
- c_wstrb  in  4  byte strobes (writes only).
- c_wdata  in  32  write data.
- c_gnt  out  1  core request accepted this cycle.
- c_rsp_valid  out  1  core response valid.
- c_rdata  out  32  core read data.
- c_fault  out  1  core access fault.
- a_req / a_we / a_word_addr / a_wstrb / a_wdata  in  1/1/30/4/32  aux request, same meaning as c_*.
- a_gnt / a_rsp_valid / a_rdata / a_fault  out  1/1/32/1  aux response, same meaning as c_*.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_word_addr  out  30  memory word address.
- mem_wstrb  out  4  memory byte strobes; 0 on reads.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  read data, valid the cycle after access.
- mem_fault  in  1  fault, valid the cycle after access.

Behaviour:
- Reset (start=0, asynchronous):
  - owner_q=0, rsp_pend_q=0, wait_cnt=0.
  - All *_rsp_valid, *_fault and *_rdata outputs 0; c_gnt=a_gnt=0; mem_en=0.
  - start deasserts synchronously to clk.
- Grant decision (combinational, same cycle):
  - force_a = a_req && (wait_cnt == MAX_WAIT).
  - a_gnt = a_req && (!c_req || force_a).
  - c_gnt = c_req && !a_gnt.
  - Never both grants high; no grant when neither requester is requesting.
- Request handshake:
  - A request is consumed only in a cycle where its gnt=1.
  - Requester holds req and payload stable until gnt; may drop req before gnt without any effect.
- Memory drive:
  - mem_en = c_gnt | a_gnt.
  - mem_we/addr/wstrb/wdata muxed from the granted requester.
  - When mem_en=0: mem_we=0, mem_wstrb=0, other memory outputs 0.
  - Reads force mem_wstrb=0 regardless of *_wstrb.
- Wait counter (registered):
  - a_gnt → 0.
  - !a_req → 0.
  - a_req && !a_gnt → saturating increment, capped at MAX_WAIT.
- Response pipeline:
  - At clk edge: rsp_pend_q ← mem_en; owner_q ← a_gnt.
  - Cycle N+1 after a grant in cycle N: the owner's rsp_valid=1 for exactly one cycle, for both reads and writes (writes get an ack).
  - Owner's rdata = mem_rdata on reads, 0 on writes; owner's fault = mem_fault.
  - The non-owner's rsp_valid/rdata/fault are 0.
- Throughput and latency:
  - Fully pipelined: back-to-back grants, including alternating owners, each get their own response one cycle later.
  - No backpressure on responses.
  - Request-to-response latency is exactly 1 cycle after gnt.
- Boundary conditions:
  - A and C request in the same cycle with wait_cnt<MAX_WAIT: C granted.
  - With wait_cnt==MAX_WAIT: A granted, C stalls one cycle.
  - A faulting access still yields one rsp_valid cycle, with fault=1 and rdata=mem_rdata.
  - Reset asserted while a response is pending: the response is dropped; no rsp_valid after reset release until a new grant.

Test Plan:
- Reset then idle: start=0 for 3 cycles, then idle → all outputs 0, mem_en=0, no rsp_valid.
- Core read: c_req=1, c_we=0, c_word_addr=0x0000_0010, mem_rdata=0xDEAD_BEEF next cycle → c_gnt=1 and mem_en=1 in cycle N; cycle N+1 c_rsp_valid=1, c_rdata=0xDEAD_BEEF, a_rsp_valid=0.
- Contention with MAX_WAIT=4: c_req and a_req held high continuously → c_gnt for 4 cycles; 5th cycle a_gnt=1, c_gnt=0; wait_cnt back to 0; pattern repeats every 5 cycles.
- Alternating owners:
  - Stimulus: C read of word 0x4, then A write of word 0x8 with a_wstrb=0x3 and a_wdata=0x1234_5678, back-to-back, A forced.
  - Cycle 1 response: c_rsp_valid=1.
  - Cycle 2 response: a_rsp_valid=1, a_rdata=0.
  - Memory drive for the A write: mem_wstrb=0x3, mem_wdata=0x1234_5678.
- Fault: A read with mem_fault=1 returned → a_rsp_valid=1, a_fault=1, c_fault=0.
- Reset mid-op: grant a C read, assert start=0 in cycle N+1 before the edge → c_rsp_valid=0 immediately; after release there is no stray response.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for a single-port data memory with 1-cycle read latency.
// Core (C) has fixed priority; a bounded wait counter force-grants the aux master (A).
module dmem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        start,

  input  logic        c_req,
  input  logic        c_we,
  input  logic [29:0] c_word_addr,
  input  logic [3:0]  c_wstrb,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rsp_valid,
  output logic [31:0] c_rdata,
  output logic        c_fault,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [29:0] a_word_addr,
  input  logic [3:0]  a_wstrb,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rsp_valid,
  output logic [31:0] a_rdata,
  output logic        a_fault,

  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_word_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_fault
);

  localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_rsp_pend;
  logic              r_owner_a;
  logic              r_rd;

  logic              w_force_a;
  logic              w_a_gnt;
  logic              w_c_gnt;
  logic              w_mem_en;

  // Handshake: a request (req + payload) is consumed only in a cycle where its
  // gnt is high; the requester holds it stable until then and may withdraw it
  // before gnt without effect. Responses have no backpressure and arrive
  // exactly one cycle after gnt. Grants are suppressed while start is low.
  assign w_force_a = a_req && (r_wait_cnt == LP_MAX_WAIT);
  assign w_a_gnt   = start && a_req && (!c_req || w_force_a);
  assign w_c_gnt   = start && c_req && !w_a_gnt;
  assign w_mem_en  = w_c_gnt || w_a_gnt;

  assign c_gnt  = w_c_gnt;
  assign a_gnt  = w_a_gnt;
  assign mem_en = w_mem_en;

  always_comb begin
    mem_we        = 1'b0;
    mem_word_addr = '0;
    mem_wstrb     = '0;
    mem_wdata     = '0;
    if (w_a_gnt) begin
      mem_we        = a_we;
      mem_word_addr = a_word_addr;
      mem_wstrb     = a_we ? a_wstrb : 4'b0000;
      mem_wdata     = a_wdata;
    end else if (w_c_gnt) begin
      mem_we        = c_we;
      mem_word_addr = c_word_addr;
      mem_wstrb     = c_we ? c_wstrb : 4'b0000;
      mem_wdata     = c_wdata;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_wait_cnt <= '0;
      r_rsp_pend <= 1'b0;
      r_owner_a  <= 1'b0;
      r_rd       <= 1'b0;
    end else begin
      r_rsp_pend <= w_mem_en;
      r_owner_a  <= w_a_gnt;
      r_rd       <= w_mem_en && !mem_we;
      if (w_a_gnt || !a_req) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != LP_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Responses are steered by the owner captured at grant time; writes return an ack with zero data.
  assign c_rsp_valid = r_rsp_pend && !r_owner_a;
  assign a_rsp_valid = r_rsp_pend && r_owner_a;
  assign c_rdata     = (c_rsp_valid && r_rd) ? mem_rdata : 32'h0;
  assign a_rdata     = (a_rsp_valid && r_rd) ? mem_rdata : 32'h0;
  assign c_fault     = c_rsp_valid && mem_fault;
  assign a_fault     = a_rsp_valid && mem_fault;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: the bench plays the memory and both requesters,
// predicts grants from the priority/fairness rules and scores responses from a queue.
module tb_dmem_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        start;
  logic        c_req, c_we;
  logic [29:0] c_word_addr;
  logic [3:0]  c_wstrb;
  logic [31:0] c_wdata;
  logic        c_gnt, c_rsp_valid, c_fault;
  logic [31:0] c_rdata;
  logic        a_req, a_we;
  logic [29:0] a_word_addr;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata;
  logic        a_gnt, a_rsp_valid, a_fault;
  logic [31:0] a_rdata;
  logic        mem_en, mem_we;
  logic [29:0] mem_word_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_fault;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk(clk), .start(start),
    .c_req(c_req), .c_we(c_we), .c_word_addr(c_word_addr), .c_wstrb(c_wstrb),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata),
    .c_fault(c_fault),
    .a_req(a_req), .a_we(a_we), .a_word_addr(a_word_addr), .a_wstrb(a_wstrb),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .a_fault(a_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_word_addr(mem_word_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_fault(mem_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected response word: {owner_is_a, fault, rdata}
  logic [33:0] exp_q[$];

  // model state
  int          m_refused;      // consecutive cycles A was refused while requesting
  logic        stg_valid;      // an access was granted this cycle, response due next cycle
  logic [33:0] stg_word;
  logic [31:0] stg_rdata;
  logic        stg_fault;
  logic [31:0] nxt_rdata;      // what the bench-memory returns for this cycle's access
  logic        nxt_fault;
  logic        last_c_gnt, last_a_gnt;
  int          a_gnt_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: open a cycle (after the edge), release the due response into the scoreboard
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    if (stg_valid) begin
      exp_q.push_back(stg_word);
      mem_rdata = stg_rdata;
      mem_fault = stg_fault;
    end else begin
      mem_rdata = $urandom;
      mem_fault = 1'($urandom_range(0, 1));
    end
    stg_valid = 1'b0;
  endtask

  // driver: close a cycle, check the grant/memory drive, stage the expected response
  task automatic end_cycle();
    logic        e_a, e_c, e_we;
    logic [29:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    #1;
    e_a = start && a_req && (!c_req || m_refused >= MAX_WAIT);
    e_c = start && c_req && !e_a;
    check("a_gnt", 64'(a_gnt), 64'(e_a));
    check("c_gnt", 64'(c_gnt), 64'(e_c));
    check("mem_en", 64'(mem_en), 64'(e_a | e_c));
    e_we = 1'b0; e_addr = '0; e_strb = '0; e_wdata = '0;
    if (e_a) begin
      e_we = a_we; e_addr = a_word_addr; e_strb = a_we ? a_wstrb : 4'h0; e_wdata = a_wdata;
    end else if (e_c) begin
      e_we = c_we; e_addr = c_word_addr; e_strb = c_we ? c_wstrb : 4'h0; e_wdata = c_wdata;
    end
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_word_addr", 64'(mem_word_addr), 64'(e_addr));
    check("mem_wstrb", 64'(mem_wstrb), 64'(e_strb));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    if (a_gnt) a_gnt_seen++;
    if (e_a || e_c) begin
      stg_valid = 1'b1;
      stg_rdata = nxt_rdata;
      stg_fault = nxt_fault;
      stg_word  = {e_a, nxt_fault, (e_we ? 32'h0 : nxt_rdata)};
    end
    if (!start || !a_req || e_a) m_refused = 0;
    else if (m_refused < MAX_WAIT) m_refused++;
    last_c_gnt = e_c;
    last_a_gnt = e_a;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_word_addr = '0; c_wstrb = '0; c_wdata = '0;
    a_req = 0; a_we = 0; a_word_addr = '0; a_wstrb = '0; a_wdata = '0;
  endtask

  // monitor / scoreboard: every cycle compares response outputs with the queue head
  always @(negedge clk) begin
    logic [33:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_valid{c,a}", 64'({c_rsp_valid, a_rsp_valid}), 64'(e[33] ? 2'b01 : 2'b10));
      if (e[33]) begin
        check("a_rdata", 64'(a_rdata), 64'(e[31:0]));
        check("a_fault", 64'(a_fault), 64'(e[32]));
        check("c_idle_out", 64'({c_fault, c_rdata}), 64'(0));
      end else begin
        check("c_rdata", 64'(c_rdata), 64'(e[31:0]));
        check("c_fault", 64'(c_fault), 64'(e[32]));
        check("a_idle_out", 64'({a_fault, a_rdata}), 64'(0));
      end
    end else begin
      check("no_rsp", 64'({c_rsp_valid, a_rsp_valid, c_fault, a_fault}), 64'(0));
      check("no_rdata", {c_rdata, a_rdata}, 64'(0));
    end
  end

  initial begin
    start = 1'b0;
    idle_inputs();
    mem_rdata = '0; mem_fault = 1'b0;
    nxt_rdata = '0; nxt_fault = 1'b0;
    m_refused = 0; stg_valid = 1'b0; stg_word = '0; stg_rdata = '0; stg_fault = 1'b0;
    last_c_gnt = 1'b0; last_a_gnt = 1'b0; a_gnt_seen = 0;

    // reset for 3 cycles, then idle
    repeat (3) begin begin_cycle(); end_cycle(); end
    begin_cycle(); start = 1'b1; end_cycle();
    repeat (2) begin begin_cycle(); end_cycle(); end

    // core read
    begin_cycle();
    c_req = 1; c_we = 0; c_word_addr = 30'h10;
    nxt_rdata = 32'hDEAD_BEEF; nxt_fault = 1'b0;
    end_cycle();
    begin_cycle(); idle_inputs(); end_cycle();

    // contention: C read of word 0x4 and A write of word 0x8 held for 10 cycles
    a_gnt_seen = 0;
    for (int i = 0; i < 10; i++) begin
      begin_cycle();
      c_req = 1; c_we = 0; c_word_addr = 30'h4; c_wstrb = 4'hF; c_wdata = 32'hCAFE_0000;
      a_req = 1; a_we = 1; a_word_addr = 30'h8; a_wstrb = 4'h3; a_wdata = 32'h1234_5678;
      nxt_rdata = $urandom; nxt_fault = 1'b0;
      end_cycle();
      if (i == 4 || i == 9) check("forced_a_slot", 64'({a_gnt, c_gnt}), 64'(2'b10));
    end
    check("a_grants_in_10", 64'(a_gnt_seen), 64'(2));
    begin_cycle(); idle_inputs(); end_cycle();

    // aux read returning a fault
    begin_cycle();
    a_req = 1; a_we = 0; a_word_addr = 30'h3FF0_0001;
    nxt_rdata = 32'hBAD0_0BAD; nxt_fault = 1'b1;
    end_cycle();
    begin_cycle(); idle_inputs(); end_cycle();

    // reset while a core read response is pending
    begin_cycle();
    c_req = 1; c_we = 0; c_word_addr = 30'h20;
    nxt_rdata = 32'h5555_AAAA; nxt_fault = 1'b0;
    end_cycle();
    @(posedge clk); #1;
    mem_rdata = 32'h5555_AAAA; mem_fault = 1'b0;
    check("rsp_before_reset", 64'(c_rsp_valid), 64'(1));
    start = 1'b0; stg_valid = 1'b0; m_refused = 0;
    c_req = 1; a_req = 1;
    #1;
    check("rsp_dropped_by_reset", 64'({c_rsp_valid, c_rdata}), 64'(0));
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); start = 1'b1; idle_inputs(); end_cycle();
    repeat (3) begin begin_cycle(); end_cycle(); end

    // randomized traffic; unrefused requests may be withdrawn or replaced
    for (int n = 0; n < 400; n++) begin
      begin_cycle();
      if (!c_req || last_c_gnt || $urandom_range(0, 7) == 0) begin
        c_req = ($urandom_range(0, 2) != 0);
        c_we = 1'($urandom_range(0, 1)); c_word_addr = 30'($urandom);
        c_wstrb = 4'($urandom); c_wdata = $urandom;
      end
      if (!a_req || last_a_gnt || $urandom_range(0, 15) == 0) begin
        a_req = ($urandom_range(0, 1) != 0);
        a_we = 1'($urandom_range(0, 1)); a_word_addr = 30'($urandom);
        a_wstrb = 4'($urandom); a_wdata = $urandom;
      end
      nxt_rdata = $urandom;
      nxt_fault = ($urandom_range(0, 7) == 0);
      end_cycle();
    end

    begin_cycle(); idle_inputs(); end_cycle();
    begin_cycle(); end_cycle();
    @(negedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
